// File: rtl/cpu_step_display.sv
// Board companion for the single-cycle CPU: debounces the step button into a
// one-edge-per-press CPU clock and scans a switch-selected byte pair onto a
// 4-digit active-low seven-segment display.
module cpu_step_display #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV        = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        btn_step,
  input  logic [1:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic [4:0]  rs_addr,
  input  logic [31:0] rs_data,
  input  logic [4:0]  rt_addr,
  input  logic [31:0] rt_data,
  input  logic [31:0] alu_result,
  input  logic [31:0] db,
  output logic        cpu_clk,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  logic            r_btn_s1, r_btn_s2;
  logic [1:0]      r_sel_s1, r_sel_s2;
  logic [1:0]      r_state;
  logic [DB_W-1:0] r_cnt;
  logic            r_cpu_clk;
  logic [SC_W-1:0] r_scan;
  logic [1:0]      r_idx;
  logic [3:0]      r_an;
  logic [7:0]      r_seg;

  logic [7:0]      w_left, w_right;
  logic [3:0]      w_nibble;
  logic [6:0]      w_dec;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_sel_s1 <= 2'b00;
      r_sel_s2 <= 2'b00;
    end else begin
      r_btn_s1 <= btn_step;
      r_btn_s2 <= r_btn_s1;
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
    end
  end

  // cpu_clk only changes after the synchronized button has held one level
  // for the full debounce window; shorter excursions fall back silently.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_cpu_clk <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_btn_s2) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!r_btn_s2) begin
            r_state <= ST_IDLE;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= ST_PRESSED;
            r_cpu_clk <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!r_btn_s2) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (r_btn_s2) begin
            r_state <= ST_PRESSED;
          end else if (r_cnt == DB_LAST) begin
            r_state   <= ST_IDLE;
            r_cpu_clk <= 1'b0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_left  = pc[7:0];
    w_right = next_pc[7:0];
    case (r_sel_s2)
      2'b01: begin w_left = {3'b000, rs_addr}; w_right = rs_data[7:0]; end
      2'b10: begin w_left = {3'b000, rt_addr}; w_right = rt_data[7:0]; end
      2'b11: begin w_left = alu_result[7:0];   w_right = db[7:0];      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_idx)
      2'd3:    w_nibble = w_left[7:4];
      2'd2:    w_nibble = w_left[3:0];
      2'd1:    w_nibble = w_right[7:4];
      default: w_nibble = w_right[3:0];
    endcase
  end

  always_comb begin
    case (w_nibble)
      4'h0: w_dec = 7'b1000000;
      4'h1: w_dec = 7'b1111001;
      4'h2: w_dec = 7'b0100100;
      4'h3: w_dec = 7'b0110000;
      4'h4: w_dec = 7'b0011001;
      4'h5: w_dec = 7'b0010010;
      4'h6: w_dec = 7'b0000010;
      4'h7: w_dec = 7'b1111000;
      4'h8: w_dec = 7'b0000000;
      4'h9: w_dec = 7'b0010000;
      4'hA: w_dec = 7'b0001000;
      4'hB: w_dec = 7'b0000011;
      4'hC: w_dec = 7'b1000110;
      4'hD: w_dec = 7'b0100001;
      4'hE: w_dec = 7'b0000110;
      default: w_dec = 7'b0001110;
    endcase
  end

  // an/seg are registered from the current index, so they trail it by a cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
      r_an   <= 4'b1111;
      r_seg  <= 8'hFF;
    end else begin
      if (r_scan == SC_LAST) begin
        r_scan <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_scan <= r_scan + SC_W'(1);
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= {1'b1, w_dec};
    end
  end

  assign cpu_clk = r_cpu_clk;
  assign an      = r_an;
  assign seg     = r_seg;

endmodule

// File: tb/tb_cpu_step_display.sv
// Directed bench for cpu_step_display with a short debounce window and fast scan.
module tb_cpu_step_display;

  logic        CLK = 1'b0;
  logic        RST;
  logic        btn_step;
  logic [1:0]  sel;
  logic [31:0] pc, next_pc, rs_data, rt_data, alu_result, db;
  logic [4:0]  rs_addr, rt_addr;
  logic        cpu_clk;
  logic [3:0]  an;
  logic [7:0]  seg;

  int checks   = 0;
  int failures = 0;

  cpu_step_display #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(2)) dut (
    .CLK(CLK), .RST(RST), .btn_step(btn_step), .sel(sel),
    .pc(pc), .next_pc(next_pc), .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_addr(rt_addr), .rt_data(rt_data), .alu_result(alu_result), .db(db),
    .cpu_clk(cpu_clk), .an(an), .seg(seg)
  );

  always #5 CLK = ~CLK;

  // Waits (bounded) for a given digit enable; the caller compares the outcome.
  task automatic wait_an(input logic [3:0] want, output bit found);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (an === want) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL reset_cpu_clk got=%b exp=0", cpu_clk); end
    checks++;
    if (an !== 4'b1111) begin failures++; $display("FAIL reset_an got=%b exp=1111", an); end
    checks++;
    if (seg !== 8'hFF) begin failures++; $display("FAIL reset_seg got=%h exp=ff", seg); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_scan();
    logic [3:0] exp_an [9];
    exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011,
               4'b0111, 4'b0111, 4'b1110};
    for (int i = 0; i < 9; i++) begin
      @(posedge CLK); #1;
      checks++;
      if (an !== exp_an[i]) begin
        failures++;
        $display("FAIL scan_an[%0d] got=%b exp=%b", i, an, exp_an[i]);
      end
    end
  endtask

  task automatic test_press();
    int  rise_lat, fall_lat, rises, falls;
    logic prev;
    @(negedge CLK);
    btn_step = 1'b1;
    rise_lat = -1; rises = 0; prev = cpu_clk;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (cpu_clk === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (rise_lat < 0) rise_lat = i;
      end
      prev = cpu_clk;
    end
    checks++;
    if (rise_lat < 5 || rise_lat > 7) begin failures++; $display("FAIL press_latency got=%0d exp=5..7", rise_lat); end
    checks++;
    if (rises != 1) begin failures++; $display("FAIL press_edge_count got=%0d exp=1", rises); end
    checks++;
    if (cpu_clk !== 1'b1) begin failures++; $display("FAIL press_held_level got=%b exp=1", cpu_clk); end
    @(negedge CLK);
    btn_step = 1'b0;
    fall_lat = -1; falls = 0; prev = cpu_clk;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (cpu_clk === 1'b0 && prev === 1'b1) begin
        falls++;
        if (fall_lat < 0) fall_lat = i;
      end
      prev = cpu_clk;
    end
    checks++;
    if (fall_lat < 5 || fall_lat > 7) begin failures++; $display("FAIL release_latency got=%0d exp=5..7", fall_lat); end
    checks++;
    if (falls != 1 || cpu_clk !== 1'b0) begin
      failures++;
      $display("FAIL release_edge got_falls=%0d level=%b exp_falls=1 level=0", falls, cpu_clk);
    end
  endtask

  task automatic test_bounce();
    int highs;
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (i % 2 == 0) btn_step = ~btn_step;
      if (cpu_clk !== 1'b0) highs++;
    end
    @(negedge CLK);
    btn_step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (cpu_clk !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin failures++; $display("FAIL bounce_no_edge got_high_samples=%0d exp=0", highs); end
  endtask

  task automatic test_display();
    logic [1:0] sel_t [16];
    logic [3:0] an_t  [16];
    logic [7:0] seg_t [16];
    bit found;
    // Digits per page, left to right: 00 -> 0,4,0,8  01 -> 1,F,5,A
    // 10 -> 1,2,D,9  11 -> A,F,3,C
    sel_t = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11,
              2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    an_t  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111,
              4'b0111, 4'b1110, 4'b1011, 4'b1101,
              4'b0111, 4'b1011, 4'b1101, 4'b1110,
              4'b0111, 4'b1011, 4'b1101, 4'b1110};
    seg_t = '{8'h80, 8'hC0, 8'h99, 8'hC0,
              8'h88, 8'hC6, 8'h8E, 8'hB0,
              8'hF9, 8'h8E, 8'h92, 8'h88,
              8'hF9, 8'hA4, 8'hA1, 8'h90};
    @(negedge CLK);
    pc = 32'h0000_0004; next_pc = 32'h0000_0008;
    rs_addr = 5'h1F; rs_data = 32'h1234_565A;
    rt_addr = 5'h12; rt_data = 32'hCAFE_00D9;
    alu_result = 32'hDEAD_BEAF; db = 32'h0BAD_F03C;
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || sel_t[i] != sel_t[i-1]) begin
        @(negedge CLK);
        sel = sel_t[i];
        repeat (6) @(posedge CLK);
      end
      wait_an(an_t[i], found);
      checks++;
      if (!found || seg !== seg_t[i]) begin
        failures++;
        $display("FAIL display[%0d] sel=%b an_found=%0d got_seg=%h exp_seg=%h on_an=%b",
                 i, sel_t[i], found, seg, seg_t[i], an_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int rise_lat;
    bit reached;
    @(negedge CLK);
    btn_step = 1'b1;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (cpu_clk === 1'b1) begin reached = 1'b1; break; end
    end
    checks++;
    if (!reached) begin failures++; $display("FAIL midreset_press_reached got=0 exp=1"); end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL midreset_cpu_clk_drop got=%b exp=0", cpu_clk); end
    checks++;
    if (an !== 4'b1111 || seg !== 8'hFF) begin
      failures++;
      $display("FAIL midreset_display got_an=%b got_seg=%h exp_an=1111 exp_seg=ff", an, seg);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    rise_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge CLK); #1;
      if (cpu_clk === 1'b1) begin rise_lat = i; break; end
    end
    checks++;
    if (rise_lat < 5 || rise_lat > 7) begin failures++; $display("FAIL midreset_repress_latency got=%0d exp=5..7", rise_lat); end
    @(negedge CLK);
    btn_step = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL midreset_final_release got=%b exp=0", cpu_clk); end
  endtask

  initial begin
    RST = 1'b0; btn_step = 1'b0; sel = 2'b00;
    pc = '0; next_pc = '0; rs_addr = '0; rs_data = '0;
    rt_addr = '0; rt_data = '0; alu_result = '0; db = '0;
    test_reset();
    test_scan();
    test_press();
    test_bounce();
    test_display();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
